// File: rtl/frq_div_pkg.sv
// Shared definitions for the multi-channel ROM-controlled frequency divider:
// divisor ROM, output mode codes and the counter width legality helper.
package frq_div_pkg;

    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    // Divisor ROM: D(k) = 2*(k+1). Always even, so square mode is an exact 50% duty.
    function automatic int unsigned div_rom(input int unsigned sel);
        return 2 * (sel + 1);
    endfunction

    // The counter must hold D-1 for the largest select code, i.e. 2**(SEL_W+1)-1.
    function automatic bit cnt_w_ok(input int cnt_w, input int sel_w);
        return cnt_w >= sel_w + 1;
    endfunction

endpackage

// File: rtl/frq_div_channel.sv
// One divider channel: period counter, active select code, registered
// divided output and the one-cycle ratio-update pulse.
module frq_div_channel
    import frq_div_pkg::*;
#(
    parameter int SEL_W = 5,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic [SEL_W-1:0] sel_i,
    input  logic             sync_i,
    output logic             clk_out_o,
    output logic             upd_o,
    output logic [SEL_W-1:0] act_sel_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] act_sel_q, act_sel_d;
    logic             out_q, out_d;
    logic             upd_q, upd_d;

    logic [CNT_W-1:0] last_cnt;
    logic [CNT_W-1:0] half_cnt;
    logic             wrap;
    logic             boundary;

    // Divisor of the active ratio, expressed as the wrap value and the square-mode threshold.
    always_comb begin
        last_cnt = CNT_W'(div_rom(32'(act_sel_q)) - 32'd1);
        half_cnt = CNT_W'(div_rom(32'(act_sel_q)) >> 1);
        wrap     = (cnt_q == last_cnt);
        boundary = wrap || sync_i;
    end

    // Next-state: count, select new ratio only at a period boundary, derive output from current count.
    always_comb begin
        cnt_d     = cnt_q;
        act_sel_d = act_sel_q;
        out_d     = out_q;
        upd_d     = 1'b0;
        if (!en_i) begin
            // Disabled channels idle at phase 0 and silently follow the select input.
            cnt_d     = '0;
            out_d     = 1'b0;
            act_sel_d = sel_i;
        end else begin
            cnt_d = boundary ? '0 : cnt_q + CNT_W'(1);
            out_d = (mode_i == MODE_PULSE) ? wrap : (cnt_q < half_cnt);
            if (boundary) begin
                act_sel_d = sel_i;
                upd_d     = (sel_i != act_sel_q);
            end
        end
    end

    // State registers; reset loads the current select so the first period uses it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            out_q     <= 1'b0;
            upd_q     <= 1'b0;
            act_sel_q <= sel_i;
        end else begin
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            upd_q     <= upd_d;
            act_sel_q <= act_sel_d;
        end
    end

    assign clk_out_o = out_q;
    assign upd_o     = upd_q;
    assign act_sel_o = act_sel_q;

endmodule

// File: rtl/frq_divider_mc.sv
// Multi-channel clock-enable/frequency divider: N_CH independent channels
// sharing the divisor ROM and a global phase-sync strobe.
module frq_divider_mc
    import frq_div_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int SEL_W = 5,
    parameter int CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_CH-1:0]       en_i,
    input  logic [N_CH-1:0]       mode_i,
    input  logic [N_CH*SEL_W-1:0] sel_i,
    input  logic                  sync_i,
    output logic [N_CH-1:0]       clk_out_o,
    output logic [N_CH-1:0]       upd_o,
    output logic [N_CH*SEL_W-1:0] act_sel_o
);

    if (!cnt_w_ok(CNT_W, SEL_W)) begin : g_cnt_w_err
        $error("frq_divider_mc: CNT_W must be at least SEL_W+1");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        frq_div_channel #(
            .SEL_W (SEL_W),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .en_i      (en_i[i]),
            .mode_i    (mode_i[i]),
            .sel_i     (sel_i[i*SEL_W +: SEL_W]),
            .sync_i    (sync_i),
            .clk_out_o (clk_out_o[i]),
            .upd_o     (upd_o[i]),
            .act_sel_o (act_sel_o[i*SEL_W +: SEL_W])
        );
    end

endmodule

// File: tb/tb_frq_divider_mc.sv
// Bench for frq_divider_mc: constant vector table, directed corner sequences
// and randomized traffic, all checked against a period/phase reference model.
module tb_frq_divider_mc;

    localparam int N_CH  = 2;
    localparam int SEL_W = 5;
    localparam int CNT_W = 6;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [N_CH-1:0]       en_i;
    logic [N_CH-1:0]       mode_i;
    logic [N_CH*SEL_W-1:0] sel_i;
    logic                  sync_i;
    logic [N_CH-1:0]       clk_out_o;
    logic [N_CH-1:0]       upd_o;
    logic [N_CH*SEL_W-1:0] act_sel_o;

    frq_divider_mc #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en_i      (en_i),
        .mode_i    (mode_i),
        .sel_i     (sel_i),
        .sync_i    (sync_i),
        .clk_out_o (clk_out_o),
        .upd_o     (upd_o),
        .act_sel_o (act_sel_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: phase within the current period and the active select per channel.
    int phase [N_CH];
    int act   [N_CH];
    int m_out [N_CH];
    int m_upd [N_CH];

    typedef struct {
        bit       rstn;
        bit [1:0] en;
        bit [1:0] mode;
        int       sel0;
        int       sel1;
        bit       sync;
        bit [1:0] exp_out;
        bit [1:0] exp_upd;
        int       exp_act0;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int get_sel(input int c);
        return int'(sel_i[c*SEL_W +: SEL_W]);
    endfunction

    function automatic int get_act(input int c);
        return int'(act_sel_o[c*SEL_W +: SEL_W]);
    endfunction

    task automatic set_sel(input int c, input int v);
        sel_i[c*SEL_W +: SEL_W] = SEL_W'(v);
    endtask

    // Advance the model by one clock using the inputs now applied.
    task automatic model_edge();
        for (int c = 0; c < N_CH; c++) begin
            int s;
            int period;
            bit at_end;
            s = get_sel(c);
            if (!reset_n || !en_i[c]) begin
                phase[c] = 0;
                act[c]   = s;
                m_out[c] = 0;
                m_upd[c] = 0;
            end else begin
                period   = 2 * (act[c] + 1);
                at_end   = (phase[c] == period - 1);
                m_out[c] = mode_i[c] ? int'(at_end) : int'(phase[c] < period / 2);
                m_upd[c] = 0;
                if (at_end || sync_i) begin
                    m_upd[c] = int'(s != act[c]);
                    act[c]   = s;
                    phase[c] = 0;
                end else begin
                    phase[c] = phase[c] + 1;
                end
            end
        end
    endtask

    // One clock: update model, wait past the edge, compare every output with the model.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        for (int c = 0; c < N_CH; c++) begin
            check($sformatf("model_out%0d", c), int'(clk_out_o[c]), m_out[c]);
            check($sformatf("model_upd%0d", c), int'(upd_o[c]), m_upd[c]);
            check($sformatf("model_act%0d", c), get_act(c), act[c]);
        end
    endtask

    initial begin
        int outs_sq[10];
        int outs_pl[8];
        int upd_cnt;

        reset_n = 1'b0;
        en_i    = '0;
        mode_i  = '0;
        sel_i   = '0;
        sync_i  = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            phase[c] = 0; act[c] = 0; m_out[c] = 0; m_upd[c] = 0;
        end

        // ---------------- vector table ----------------
        outs_sq = '{3, 0, 3, 1, 2, 0, 3, 1, 2, 0};
        outs_pl = '{2, 0, 2, 1, 2, 0, 2, 1};
        tbl.push_back('{1'b0, 2'b11, 2'b00, 0, 0, 1'b0, 2'b00, 2'b00, 0});
        for (int i = 1; i <= 6; i++)
            tbl.push_back('{1'b1, 2'b11, 2'b00, 0, 0, 1'b0, ((i % 2) == 1) ? 2'b11 : 2'b00, 2'b00, 0});
        for (int i = 0; i < 10; i++)
            tbl.push_back('{1'b1, 2'b11, 2'b00, 1, 0, 1'b0, 2'(outs_sq[i]),
                            (i == 1) ? 2'b01 : 2'b00, (i == 0) ? 0 : 1});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{1'b1, 2'b11, 2'b01, 1, 0, 1'b0, 2'(outs_pl[i]), 2'b00, 1});

        foreach (tbl[i]) begin
            reset_n = tbl[i].rstn;
            en_i    = tbl[i].en;
            mode_i  = tbl[i].mode;
            set_sel(0, tbl[i].sel0);
            set_sel(1, tbl[i].sel1);
            sync_i  = tbl[i].sync;
            step();
            check($sformatf("tbl%0d_out", i), int'(clk_out_o), int'(tbl[i].exp_out));
            check($sformatf("tbl%0d_upd", i), int'(upd_o), int'(tbl[i].exp_upd));
            check($sformatf("tbl%0d_act0", i), get_act(0), tbl[i].exp_act0);
        end

        // ---------------- ratio switch waits for the wrap ----------------
        reset_n = 1'b0; en_i = 2'b11; mode_i = 2'b00; set_sel(0, 3); set_sel(1, 0);
        step();
        reset_n = 1'b1;
        step();
        step();
        set_sel(0, 0);
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("sw_upd_k%0d", k), int'(upd_o[0]), int'(k == 6));
            check($sformatf("sw_act_k%0d", k), get_act(0), (k == 6) ? 0 : 3);
        end
        step();
        check("sw_upd_clear", int'(upd_o[0]), 0);
        check("sw_newper_hi", int'(clk_out_o[0]), 1);
        step();
        check("sw_newper_lo", int'(clk_out_o[0]), 0);

        // ---------------- sync aligns misaligned channels ----------------
        reset_n = 1'b0; set_sel(0, 1); set_sel(1, 2);
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) step();
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        step();
        check("sync_rise", int'(clk_out_o), 3);
        step();
        check("sync_hold", int'(clk_out_o), 3);

        // ---------------- disable / re-enable one channel ----------------
        step();
        en_i = 2'b10;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("dis_out0_k%0d", k), int'(clk_out_o[0]), 0);
        end
        en_i = 2'b11;
        step();
        check("reen_ph0_a", int'(clk_out_o[0]), 1);
        step();
        check("reen_ph0_b", int'(clk_out_o[0]), 1);
        step();
        check("reen_ph0_c", int'(clk_out_o[0]), 0);

        // ---------------- reset mid-period, then sync coinciding with a wrap ----------------
        step();
        reset_n = 1'b0; set_sel(0, 5); set_sel(1, 7);
        step();
        check("rst_out", int'(clk_out_o), 0);
        check("rst_upd", int'(upd_o), 0);
        check("rst_act0", get_act(0), 5);
        check("rst_act1", get_act(1), 7);
        set_sel(0, 0);
        step();
        reset_n = 1'b1;
        step();
        set_sel(0, 2);
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        check("syncwrap_upd", int'(upd_o[0]), 1);
        check("syncwrap_act", get_act(0), 2);
        upd_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            upd_cnt += int'(upd_o[0]);
        end
        check("syncwrap_single", upd_cnt, 0);

        // ---------------- randomized traffic ----------------
        for (int n = 0; n < 1500; n++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            for (int c = 0; c < N_CH; c++) begin
                en_i[c] = ($urandom_range(0, 15) != 0);
                if ($urandom_range(0, 31) == 0) mode_i[c] = ~mode_i[c];
                if ($urandom_range(0, 19) == 0)
                    set_sel(c, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                                           : int'($urandom_range(0, 5)));
            end
            sync_i = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
